// File: rtl/column_frame_buffer.sv
// column_frame_buffer
// Double-buffered LED column store. A full column is fetched from the texture
// ROM into the back half of a two-column RAM; the halves swap only at a strip
// refresh boundary, so every refresh shows one coherent column.

module column_frame_buffer #(
    parameter int LED_COUNT  = 52,
    parameter int TEX_WIDTH  = 64,
    parameter int NUM_FRAMES = 75,
    parameter int PX_BITS    = 6,
    parameter int COL_BITS   = 6,
    parameter int FRAME_BITS = 8,
    parameter int ADDR_WIDTH = 18
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [COL_BITS-1:0]   theta,
    input  logic [FRAME_BITS-1:0] frame_idx,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [23:0]           rom_data,
    input  logic [PX_BITS-1:0]    px_num,
    input  logic                  strip_sync,
    output logic [23:0]           pixel,
    output logic                  col_valid,
    output logic                  fill_busy,
    output logic [15:0]           drop_cnt
);

    localparam int LED_BITS  = $clog2(LED_COUNT + 1);
    localparam int MEM_DEPTH = 2 * LED_COUNT;
    localparam int IDX_BITS  = $clog2(MEM_DEPTH);

    localparam logic [LED_BITS-1:0] LAST_LED = LED_BITS'(LED_COUNT - 1);
    localparam logic [LED_BITS-1:0] LED_END  = LED_BITS'(LED_COUNT);
    localparam logic [PX_BITS-1:0]  LAST_PX  = PX_BITS'(LED_COUNT - 1);

    // The ROM must be addressable with ADDR_WIDTH bits.
    if (TEX_WIDTH * LED_COUNT * NUM_FRAMES > (1 << ADDR_WIDTH)) begin : g_addr_too_narrow
        $error("column_frame_buffer: ADDR_WIDTH too small for texture ROM");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FILL  = 2'd1,
        S_READY = 2'd2
    } state_t;

    // Saturating increment for the dropped-column counter.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        if (v == 16'hFFFF) begin
            return v;
        end else begin
            return v + 16'd1;
        end
    endfunction

    state_t                state_q, state_d;
    logic [LED_BITS-1:0]   fill_led_q, fill_led_d;
    logic [COL_BITS-1:0]   fill_col_q, fill_col_d;
    logic [FRAME_BITS-1:0] fill_frame_q, fill_frame_d;
    logic                  pend_q, pend_d;
    logic [COL_BITS-1:0]   pend_col_q, pend_col_d;
    logic [FRAME_BITS-1:0] pend_frame_q, pend_frame_d;
    logic                  init_fill_q, init_fill_d;
    logic [COL_BITS-1:0]   theta_last_q;
    logic [FRAME_BITS-1:0] frame_last_q;
    logic                  front_sel_q, front_sel_d;
    logic                  col_valid_q, col_valid_d;
    logic                  fill_busy_q, fill_busy_d;
    logic [15:0]           drop_cnt_q, drop_cnt_d;
    logic                  valid_d1_q, valid_d1_d;
    logic [LED_BITS-1:0]   led_d1_q;
    logic [23:0]           pixel_q, pixel_d;

    logic                  trig_s;
    logic                  last_wr_s;
    logic [IDX_BITS-1:0]   wr_idx_s;
    logic [IDX_BITS-1:0]   rd_idx_s;

    logic [23:0] mem [MEM_DEPTH];

    assign trig_s    = init_fill_q || (theta != theta_last_q) || (frame_idx != frame_last_q);
    assign last_wr_s = (state_q == S_FILL) && valid_d1_q && (led_d1_q == LAST_LED);

    // Address arithmetic done modulo 2**ADDR_WIDTH: identical low bits to a
    // full-width product followed by truncation.
    assign rom_addr = ADDR_WIDTH'(fill_frame_q) * ADDR_WIDTH'(TEX_WIDTH * LED_COUNT)
                    + ADDR_WIDTH'(fill_led_q) * ADDR_WIDTH'(TEX_WIDTH)
                    + ADDR_WIDTH'(fill_col_q);

    // Writes go to the half not being shown; reads come only from the front.
    assign wr_idx_s = front_sel_q ? IDX_BITS'(led_d1_q)
                                  : IDX_BITS'(LED_COUNT) + IDX_BITS'(led_d1_q);
    assign rd_idx_s = front_sel_q ? IDX_BITS'(LED_COUNT) + IDX_BITS'(px_num)
                                  : IDX_BITS'(px_num);

    // Next-state logic for the fill/swap controller.
    always_comb begin
        state_d      = state_q;
        fill_led_d   = fill_led_q;
        fill_col_d   = fill_col_q;
        fill_frame_d = fill_frame_q;
        pend_d       = pend_q;
        pend_col_d   = pend_col_q;
        pend_frame_d = pend_frame_q;
        init_fill_d  = init_fill_q;
        front_sel_d  = front_sel_q;
        col_valid_d  = col_valid_q;
        drop_cnt_d   = drop_cnt_q;

        case (state_q)
            S_IDLE: begin
                if (trig_s) begin
                    state_d      = S_FILL;
                    fill_col_d   = theta;
                    fill_frame_d = frame_idx;
                    fill_led_d   = {LED_BITS{1'b0}};
                    init_fill_d  = 1'b0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_FILL: begin
                if (fill_led_q < LED_END) begin
                    fill_led_d = fill_led_q + {{(LED_BITS-1){1'b0}}, 1'b1};
                end else begin
                    fill_led_d = fill_led_q;
                end
                if (last_wr_s) begin
                    if (pend_q || trig_s) begin
                        // Finished column is superseded before display.
                        drop_cnt_d = sat_inc16(drop_cnt_q);
                        state_d    = S_FILL;
                        fill_led_d = {LED_BITS{1'b0}};
                        pend_d     = 1'b0;
                        if (trig_s) begin
                            fill_col_d   = theta;
                            fill_frame_d = frame_idx;
                        end else begin
                            fill_col_d   = pend_col_q;
                            fill_frame_d = pend_frame_q;
                        end
                    end else begin
                        state_d = S_READY;
                    end
                end else if (trig_s) begin
                    // Latest request wins; the running fill completes first.
                    pend_d       = 1'b1;
                    pend_col_d   = theta;
                    pend_frame_d = frame_idx;
                end else begin
                    pend_d = pend_q;
                end
            end
            S_READY: begin
                if (strip_sync) begin
                    front_sel_d = ~front_sel_q;
                    col_valid_d = 1'b1;
                    if (trig_s) begin
                        state_d      = S_FILL;
                        fill_col_d   = theta;
                        fill_frame_d = frame_idx;
                        fill_led_d   = {LED_BITS{1'b0}};
                    end else begin
                        state_d = S_IDLE;
                    end
                end else if (trig_s) begin
                    drop_cnt_d   = sat_inc16(drop_cnt_q);
                    state_d      = S_FILL;
                    fill_col_d   = theta;
                    fill_frame_d = frame_idx;
                    fill_led_d   = {LED_BITS{1'b0}};
                end else begin
                    state_d = S_READY;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ROM read pipeline, busy flag and front-buffer read data.
    always_comb begin
        valid_d1_d  = (state_q == S_FILL) && (fill_led_q < LED_END);
        fill_busy_d = (state_d == S_FILL);
        if (col_valid_q && (px_num <= LAST_PX)) begin
            pixel_d = mem[rd_idx_s];
        end else begin
            pixel_d = 24'h000000;
        end
    end

    // Controller and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            fill_led_q   <= {LED_BITS{1'b0}};
            fill_col_q   <= {COL_BITS{1'b0}};
            fill_frame_q <= {FRAME_BITS{1'b0}};
            pend_q       <= 1'b0;
            pend_col_q   <= {COL_BITS{1'b0}};
            pend_frame_q <= {FRAME_BITS{1'b0}};
            init_fill_q  <= 1'b1;
            theta_last_q <= {COL_BITS{1'b0}};
            frame_last_q <= {FRAME_BITS{1'b0}};
            front_sel_q  <= 1'b0;
            col_valid_q  <= 1'b0;
            fill_busy_q  <= 1'b0;
            drop_cnt_q   <= 16'h0000;
            valid_d1_q   <= 1'b0;
            led_d1_q     <= {LED_BITS{1'b0}};
            pixel_q      <= 24'h000000;
        end else begin
            state_q      <= state_d;
            fill_led_q   <= fill_led_d;
            fill_col_q   <= fill_col_d;
            fill_frame_q <= fill_frame_d;
            pend_q       <= pend_d;
            pend_col_q   <= pend_col_d;
            pend_frame_q <= pend_frame_d;
            init_fill_q  <= init_fill_d;
            theta_last_q <= theta;
            frame_last_q <= frame_idx;
            front_sel_q  <= front_sel_d;
            col_valid_q  <= col_valid_d;
            fill_busy_q  <= fill_busy_d;
            drop_cnt_q   <= drop_cnt_d;
            valid_d1_q   <= valid_d1_d;
            led_d1_q     <= fill_led_q;
            pixel_q      <= pixel_d;
        end
    end

    // Column RAM write port (contents intentionally not reset).
    always_ff @(posedge clk) begin
        if (valid_d1_q) begin
            mem[wr_idx_s] <= rom_data;
        end
    end

    assign pixel     = pixel_q;
    assign col_valid = col_valid_q;
    assign fill_busy = fill_busy_q;
    assign drop_cnt  = drop_cnt_q;

endmodule

// File: doc/column_frame_buffer.md
Name: column_frame_buffer

Overview:
- Double-buffered column store between the texture ROM and the neopixel strip controller.
- On each new angle index or animation frame, it reads one full 52-pixel column from the texture ROM into a back buffer.
- At the strip's refresh boundary it swaps the back buffer to the front, so every refresh shows one coherent column.
- This removes the column tearing that occurs when theta changes mid-refresh.

Parameters:
- LED_COUNT, 52, pixels per column / strip length
- TEX_WIDTH, 64, columns per texture frame
- NUM_FRAMES, 75, animation frames in ROM
- PX_BITS, 6, width of pixel index
- COL_BITS, 6, width of theta/column index
- FRAME_BITS, 8, width of frame index
- ADDR_WIDTH, 18, ROM address width (clog2(TEX_WIDTH*LED_COUNT*NUM_FRAMES))

Ports:
- clk  in  1  system clock (100 MHz)
- reset  in  1  asynchronous, active-high reset
- theta  in  COL_BITS  current angle index from the angle generator
- frame_idx  in  FRAME_BITS  current animation frame
- rom_addr  out  ADDR_WIDTH  texture ROM address
- rom_data  in  24  ROM data, valid 1 cycle after rom_addr
- px_num  in  PX_BITS  pixel index requested by the strip controller
- strip_sync  in  1  1-cycle pulse at start of each strip refresh
- pixel  out  24  GRB colour for px_num
- col_valid  out  1  high once the first column has been swapped to the front
- fill_busy  out  1  high while in FILL
- drop_cnt  out  16  saturating count of columns filled but never displayed

Behaviour:
- Reset (async):
  - state=IDLE; front_sel=0; pixel=0; col_valid=0; fill_busy=0; drop_cnt=0; rom_addr=0.
  - theta_last=0 and frame_last=0; init_fill=1 forces a fill on the first post-reset cycle.
  - Buffer RAM contents are not reset; outputs are gated by col_valid.
- Trigger: trig = init_fill OR theta!=theta_last OR frame_idx!=frame_last. theta_last and frame_last update every cycle.
- IDLE:
  - On trig: latch fill_col=theta and fill_frame=frame_idx; fill_led=0; clear init_fill; go to FILL.
- FILL:
  - rom_addr = fill_frame*(TEX_WIDTH*LED_COUNT) + fill_led*TEX_WIDTH + fill_col. Compute at full width, truncate to ADDR_WIDTH; combinational from registers.
  - fill_led increments every cycle while < LED_COUNT.
  - Valid pipeline delays fill_led by 1: back[led_d1] <= rom_data when the delayed valid is high.
  - Fill takes LED_COUNT+1 = 53 cycles from entry to last write.
  - trig during FILL: set pend=1 and relatch theta/frame into pend_col/pend_frame (latest wins). The current fill is not aborted.
  - On the last write:
    - If pend: drop_cnt+1 (saturating); start a new FILL with pend values; clear pend.
    - Else: go to READY.
- READY:
  - On strip_sync: toggle front_sel; col_valid<=1; go to IDLE. If trig occurs in the same cycle, go directly to FILL (swap still happens).
  - On trig without strip_sync: drop_cnt+1 (saturating); refill the back buffer (FILL).
- strip_sync during IDLE or FILL: no swap. The front is unchanged and the strip repeats the previous column.
- strip_sync coincident with fill completion: no swap that cycle; wait for the next strip_sync.
- Read port:
  - pixel <= front[px_num] registered, 1-cycle latency.
  - pixel=0 if px_num>=LED_COUNT or col_valid=0.
  - Reads never touch the back buffer.
- fill_busy = (state==FILL).
- drop_cnt saturates at 16'hFFFF.
- Storage: 2 x LED_COUNT x 24 bits, in distributed or block RAM, one write port and one read port.

Test Plan:
- Reset release, theta=5, frame=0, ROM word = address → fill_busy high 53 cycles; first strip_sync sets col_valid=1; pixel for px_num=3 is 3*64+5=197 one cycle after request.
- frame_idx=2, theta=10, after swap → px_num=51 reads 2*3328+51*64+10=9930; px_num=60 reads 0.
- theta 5→6 at cycle 20 of a fill → fill completes, refills column 6 immediately, drop_cnt=1; after the next strip_sync, pixel(0)=6.
- Two theta changes in READY before strip_sync → drop_cnt=2; the swapped column equals the final theta.
- strip_sync mid-FILL and exactly on the completion cycle → no swap, front data unchanged; swap occurs on the following strip_sync.
- Assert reset mid-FILL (cycle 30) → outputs return to reset values asynchronously; col_valid=0, pixel=0; a fresh fill starts after release.
